// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter
// Shares one TX frame BRAM and one transmitter between NUM_REQ frame
// producers. A round-robin winner owns the BRAM write port until it signals
// load_done. Its frame length is then handed to the transmit block as a
// one-entry descriptor. A stuck client loses the grant after TIMEOUT cycles.

module eth_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic [NUM_REQ-1:0]       load_done,
    input  logic                     send_data_re,
    input  logic                     tx_en,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     send_data_empty,
    output logic [LEN_W-1:0]         tx_len,
    output logic                     busy,
    output logic [7:0]               timeout_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    // The counter starts at 0 in the first GRANT cycle, so the grant is
    // revoked on the edge where the counter would reach TIMEOUT.
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_DONE
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_lastWinner;
    logic [IDX_W-1:0]   r_owner;
    logic [TO_W-1:0]    r_toCount;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_sendEmpty;
    logic [LEN_W-1:0]   r_txLen;
    logic               r_busy;
    logic [7:0]         r_timeoutCnt;

    logic               w_found;
    logic [IDX_W-1:0]   w_winner;
    logic               w_ownerDone;
    logic [LEN_W-1:0]   w_ownerLen;

    // Round-robin search starting just after the last served client.
    always_comb begin : rrSearch
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(r_lastWinner) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_found && req[IDX_W'(idx)]) begin
                w_found  = 1'b1;
                w_winner = IDX_W'(idx);
            end
        end
    end

    // Completion strobe and frame length of the current owner only.
    always_comb begin
        w_ownerDone = load_done[r_owner];
        w_ownerLen  = req_len[r_owner*LEN_W +: LEN_W];
    end

    // Arbitration and descriptor hand-off state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_sendEmpty  <= 1'b1;
            r_txLen      <= '0;
            r_busy       <= 1'b0;
            r_timeoutCnt <= '0;
            r_lastWinner <= LAST_IDX;
            r_owner      <= '0;
            r_toCount    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner   <= w_winner;
                        r_grant   <= NUM_REQ'(1) << w_winner;
                        r_toCount <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_GRANT;
                    end
                end

                S_GRANT: begin
                    // Completion wins over a timeout landing on the same edge.
                    if (w_ownerDone) begin
                        r_txLen     <= w_ownerLen;
                        r_grant     <= '0;
                        r_sendEmpty <= 1'b0;
                        r_state     <= S_ISSUE;
                    end else if (r_toCount == TO_LAST) begin
                        r_grant      <= '0;
                        if (r_timeoutCnt != 8'hFF) begin
                            r_timeoutCnt <= r_timeoutCnt + 8'd1;
                        end
                        r_lastWinner <= r_owner;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_toCount <= r_toCount + TO_W'(1);
                    end
                end

                S_ISSUE: begin
                    // The descriptor is already visible here, so an early
                    // pop is accepted rather than lost.
                    if (send_data_re) begin
                        r_sendEmpty <= 1'b1;
                        r_state     <= S_WAIT_DONE;
                    end else begin
                        r_state     <= S_WAIT_START;
                    end
                end

                S_WAIT_START: begin
                    if (send_data_re) begin
                        r_sendEmpty <= 1'b1;
                        r_state     <= S_WAIT_DONE;
                    end
                end

                S_WAIT_DONE: begin
                    if (!tx_en) begin
                        r_lastWinner <= r_owner;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_grant     <= '0;
                    r_sendEmpty <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign grant           = r_grant;
    assign send_data_empty = r_sendEmpty;
    assign tx_len          = r_txLen;
    assign busy            = r_busy;
    assign timeout_cnt     = r_timeoutCnt;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter
// Directed and randomized frames against a transaction-level model. The
// model tracks the last served client and the timeout count. It predicts
// the grant winner, the latched length, and the cycle-exact hand-off.

module tb_eth_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int LEN_W   = 16;
    localparam int TIMEOUT = 1023;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] req_len;
    logic [3:0]  load_done;
    logic        send_data_re;
    logic        tx_en;
    logic [3:0]  grant;
    logic        send_data_empty;
    logic [15:0] tx_len;
    logic        busy;
    logic [7:0]  timeout_cnt;

    int checks = 0;
    int errors = 0;
    int modelLast;
    int modelTimeouts;

    eth_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .LEN_W   (LEN_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .req_len         (req_len),
        .load_done       (load_done),
        .send_data_re    (send_data_re),
        .tx_en           (tx_en),
        .grant           (grant),
        .send_data_empty (send_data_empty),
        .tx_len          (tx_len),
        .busy            (busy),
        .timeout_cnt     (timeout_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First requesting client after the last served one, wrapping around.
    function automatic int expectWinner(input logic [3:0] r);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (modelLast + k) % NUM_REQ;
            if (r[2'(idx)]) return idx;
        end
        return 0;
    endfunction

    // One frame from an idle arbiter with req already driven.
    task automatic applyStimulus(input int loadDelay, input int popDelay, input int txCycles,
                                 input bit spurious, input bit doTimeout);
        int          w;
        int          cnt;
        logic [3:0]  expG;
        logic [15:0] expLen;
        bit          sawDesc;
        bit          sawBadGrant;
        w    = expectWinner(req);
        expG = 4'(1 << w);
        tick();
        checkOutput("grant_rr", 32'(grant), 32'(expG));
        checkOutput("busy_in_grant", 32'(busy), 32'd1);

        if (doTimeout) begin
            cnt         = 0;
            sawDesc     = 1'b0;
            sawBadGrant = 1'b0;
            while (grant !== 4'b0000 && cnt < TIMEOUT + 50) begin
                if (grant !== expG) sawBadGrant = 1'b1;
                tick();
                cnt++;
                if (send_data_empty !== 1'b1) sawDesc = 1'b1;
            end
            modelTimeouts = (modelTimeouts < 255) ? modelTimeouts + 1 : 255;
            modelLast     = w;
            checkOutput("timeout_grant_cycles", 32'(cnt), 32'(TIMEOUT));
            checkOutput("timeout_grant_stable", 32'(sawBadGrant), 32'd0);
            checkOutput("timeout_no_descriptor", 32'(sawDesc), 32'd0);
            checkOutput("timeout_count", 32'(timeout_cnt), 32'(modelTimeouts));
            checkOutput("timeout_idle", 32'(busy), 32'd0);
            return;
        end

        for (int d = 0; d < loadDelay; d++) begin
            if (spurious && d == 0) load_done = {expG[2:0], expG[3]};
            tick();
            load_done = 4'b0000;
            if (spurious && d == 0) begin
                checkOutput("ignore_foreign_done", 32'(grant), 32'(expG));
                checkOutput("no_issue_on_foreign_done", 32'(send_data_empty), 32'd1);
            end
        end
        checkOutput("grant_held", 32'(grant), 32'(expG));

        expLen    = req_len[w*LEN_W +: LEN_W];
        load_done = expG;
        tick();
        load_done = 4'b0000;
        req_len[w*LEN_W +: LEN_W] = 16'($urandom);
        checkOutput("grant_released", 32'(grant), 32'd0);
        checkOutput("descriptor_presented", 32'(send_data_empty), 32'd0);
        checkOutput("tx_len_latched", 32'(tx_len), 32'(expLen));

        for (int p = 0; p < popDelay; p++) begin
            tick();
            checkOutput("descriptor_held", 32'(send_data_empty), 32'd0);
            checkOutput("tx_len_stable", 32'(tx_len), 32'(expLen));
            checkOutput("no_grant_with_descriptor", 32'(grant), 32'd0);
        end

        send_data_re = 1'b1;
        tx_en        = 1'b1;
        tick();
        send_data_re = 1'b0;
        checkOutput("descriptor_popped", 32'(send_data_empty), 32'd1);
        for (int t = 0; t < txCycles; t++) tick();
        checkOutput("busy_while_tx", 32'(busy), 32'd1);
        checkOutput("no_grant_while_tx", 32'(grant), 32'd0);

        tx_en = 1'b0;
        tick();
        modelLast = w;
        checkOutput("idle_after_tx", 32'(busy), 32'd0);
        checkOutput("no_timeout_counted", 32'(timeout_cnt), 32'(modelTimeouts));
    endtask

    initial begin
        $display("[TB] eth_tx_arbiter bench start");
        reset         = 1'b1;
        req           = 4'b0000;
        req_len       = 64'h0;
        load_done     = 4'b0000;
        send_data_re  = 1'b0;
        tx_en         = 1'b0;
        modelLast     = NUM_REQ - 1;
        modelTimeouts = 0;

        tick();
        tick();
        checkOutput("reset_grant", 32'(grant), 32'd0);
        checkOutput("reset_empty", 32'(send_data_empty), 32'd1);
        checkOutput("reset_tx_len", 32'(tx_len), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_timeout_cnt", 32'(timeout_cnt), 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("idle_no_req", 32'(busy), 32'd0);

        // All clients requesting continuously: served 0,1,2,3,0.
        req     = 4'b1111;
        req_len = {16'd40, 16'd30, 16'd20, 16'd10};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1 + i % 3, 1 + i % 2, i % 3, 1'b0, 1'b0);
        end
        req = 4'b0000;

        // Single client, completion five cycles into the grant, length 8.
        req_len        = 64'h0;
        req_len[15:0]  = 16'd8;
        req            = 4'b0001;
        applyStimulus(5, 1, 3, 1'b0, 1'b0);
        req = 4'b0000;

        // Foreign load_done while client 0 owns the BRAM.
        req = 4'b0011;
        modelLast = modelLast;
        req = 4'b0001;
        applyStimulus(3, 2, 2, 1'b1, 1'b0);
        req = 4'b0000;

        // Client that never finishes is revoked after TIMEOUT cycles.
        req = 4'b0100;
        applyStimulus(0, 0, 0, 1'b0, 1'b1);
        req = 4'b0000;

        // Completion on the very cycle the timeout would fire.
        req_len[63:48] = 16'd1234;
        req            = 4'b1000;
        applyStimulus(TIMEOUT - 1, 1, 0, 1'b0, 1'b0);
        req = 4'b0000;

        // Randomized request patterns, lengths (including zero) and timing.
        for (int i = 0; i < 40; i++) begin
            req     = 4'($urandom_range(1, 15));
            req_len = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) req_len = 64'h0;
            applyStimulus(int'($urandom_range(0, 6)), int'($urandom_range(1, 3)),
                          int'($urandom_range(0, 4)), ($urandom_range(0, 1) == 1), 1'b0);
        end
        req = 4'b0000;

        // Reset while a descriptor waits for the transmitter.
        req            = 4'b0100;
        req_len[47:32] = 16'd77;
        tick();
        checkOutput("pre_reset_grant", 32'(grant), 32'(4'(1 << expectWinner(4'b0100))));
        load_done = 4'b0100;
        tick();
        load_done = 4'b0000;
        req       = 4'b0000;
        tick();
        checkOutput("pre_reset_descriptor", 32'(send_data_empty), 32'd0);
        reset = 1'b1;
        tick();
        reset         = 1'b0;
        modelLast     = NUM_REQ - 1;
        modelTimeouts = 0;
        checkOutput("abort_grant", 32'(grant), 32'd0);
        checkOutput("abort_empty", 32'(send_data_empty), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_tx_len", 32'(tx_len), 32'd0);
        checkOutput("abort_timeout_cnt", 32'(timeout_cnt), 32'd0);
        repeat (3) tick();
        checkOutput("abort_no_descriptor", 32'(send_data_empty), 32'd1);
        req = 4'b0010;
        applyStimulus(2, 1, 1, 1'b0, 1'b0);
        req = 4'b0000;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
